// File: rtl/klog_pkg.sv
// Shared widths, latency and read-FSM encoding for the k-map log capture buffer.
package klog_pkg;

    localparam int KLOG_ADDR_W = 15;
    localparam int KLOG_DATA_W = 32;
    localparam int KLOG_RD_LAT = 2;
    localparam int KLOG_CNT_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } klog_state_e;

    function automatic logic [KLOG_CNT_W-1:0] klog_wait_init(input int rd_lat);
        return KLOG_CNT_W'(rd_lat - 1);
    endfunction

endpackage

// File: rtl/klog_dpram.sv
// Simple dual-port RAM: one write port, one read port with a synchronous read
// followed by RD_LAT-1 output stages; a same-edge collision returns old data.
module klog_dpram #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem    [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] pipe_q [0:RD_LAT-1];

    // Write port, synchronous read and output pipeline; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            pipe_q[0] <= mem[raddr];
        end
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign rdata = pipe_q[RD_LAT-1];

endmodule

// File: rtl/klog_capture_buffer.sv
// K-map log capture buffer: circular sample log in RAM plus an address-change
// driven read FSM that never shows stale data with r_valid high.
module klog_capture_buffer
    import klog_pkg::*;
#(
    parameter int ADDR_W = KLOG_ADDR_W,
    parameter int DATA_W = KLOG_DATA_W,
    parameter int RD_LAT = KLOG_RD_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              log_enable,
    input  logic              log_clear,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              wrapped
);

    localparam logic [KLOG_CNT_W-1:0] WAIT_INIT = klog_wait_init(RD_LAT);

    klog_state_e             state_q, state_d;
    logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic                    wrapped_q, wrapped_d;
    logic [DATA_W-1:0]       r_data_q, r_data_d;
    logic                    r_valid_q, r_valid_d;
    logic [ADDR_W-1:0]       last_addr_q, last_addr_d;
    logic                    pending_q, pending_d;
    logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
    logic [KLOG_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    wr_en;
    logic                    addr_chg;
    logic [DATA_W-1:0]       ram_q;

    assign wr_en    = wr_valid & log_enable & ~log_clear;
    assign addr_chg = (r_addr != last_addr_q);

    klog_dpram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .re    (state_q == ST_ISSUE),
        .raddr (rd_addr_q),
        .rdata (ram_q)
    );

    // Next-state logic for the write pointer and the read FSM.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wrapped_d   = wrapped_q;
        r_data_d    = r_data_q;
        r_valid_d   = r_valid_q & ~addr_chg;
        last_addr_d = r_addr;
        pending_d   = pending_q;
        rd_addr_d   = rd_addr_q;
        cnt_d       = cnt_q;

        if (log_clear) begin
            wr_ptr_d  = {ADDR_W{1'b0}};
            wrapped_d = 1'b0;
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (wr_ptr_q == {ADDR_W{1'b1}}) begin
                wrapped_d = 1'b1;
            end else begin
                wrapped_d = wrapped_q;
            end
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        // An address change during ISSUE/WAIT restarts the read instead of queuing it.
        if (log_clear) begin
            state_d   = ST_IDLE;
            pending_d = 1'b1;
            r_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pending_q) begin
                        state_d   = ST_ISSUE;
                        rd_addr_d = r_addr;
                        pending_d = 1'b0;
                    end else if (addr_chg) begin
                        pending_d = 1'b1;
                    end else begin
                        pending_d = 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (addr_chg) begin
                        rd_addr_d = r_addr;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
                ST_WAIT: begin
                    if (addr_chg) begin
                        state_d   = ST_ISSUE;
                        rd_addr_d = r_addr;
                    end else if (cnt_q == {KLOG_CNT_W{1'b0}}) begin
                        r_data_d  = ram_q;
                        r_valid_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - KLOG_CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers; reset forces a read of the current address once released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= {ADDR_W{1'b0}};
            wrapped_q   <= 1'b0;
            r_data_q    <= {DATA_W{1'b0}};
            r_valid_q   <= 1'b0;
            last_addr_q <= {ADDR_W{1'b0}};
            pending_q   <= 1'b1;
            rd_addr_q   <= {ADDR_W{1'b0}};
            cnt_q       <= {KLOG_CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wrapped_q   <= wrapped_d;
            r_data_q    <= r_data_d;
            r_valid_q   <= r_valid_d;
            last_addr_q <= last_addr_d;
            pending_q   <= pending_d;
            rd_addr_q   <= rd_addr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign r_data  = r_data_q;
    assign r_valid = r_valid_q;
    assign wr_ptr  = wr_ptr_q;
    assign wrapped = wrapped_q;

endmodule

// File: tb/tb_klog_capture_buffer.sv
// Directed bench for klog_capture_buffer: expected read results go into a
// scoreboard queue that a negedge monitor drains on each rising r_valid.
module tb_klog_capture_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        log_enable = 1'b0;
    logic        log_clear = 1'b0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = 32'd0;
    logic [14:0] r_addr = 15'd0;
    logic [31:0] r_data;
    logic        r_valid;
    logic [14:0] wr_ptr;
    logic        wrapped;

    int          n_total = 0;
    int          n_pass = 0;
    logic [32:0] exp_q[$];
    logic [32:0] exp_e;
    logic        mon_prev = 1'b0;

    klog_capture_buffer dut (
        .clk        (clk),
        .reset      (rst),
        .log_enable (log_enable),
        .log_clear  (log_clear),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .r_addr     (r_addr),
        .r_data     (r_data),
        .r_valid    (r_valid),
        .wr_ptr     (wr_ptr),
        .wrapped    (wrapped)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total = n_total + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // r_valid must stay low for n-1 edges and be high after the n-th.
    task automatic lat_check(input int n, input string name);
        for (int i = 1; i < n; i++) begin
            step();
            check({name, "_low"}, 32'(r_valid), 32'd0);
        end
        step();
        check({name, "_high"}, 32'(r_valid), 32'd1);
    endtask

    // Monitor: every rising r_valid consumes one scoreboard entry.
    always @(negedge clk) begin
        if (r_valid && !mon_prev) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_e = exp_q.pop_front();
                if (exp_e[32]) begin
                    check("sb_rdata", r_data, exp_e[31:0]);
                end
            end
        end
        mon_prev = r_valid;
    end

    initial begin
        // 1: reset values, then forced read of address 0 (RAM content unknown).
        #12;
        check("rst_r_valid", 32'(r_valid), 32'd0);
        check("rst_r_data", r_data, 32'd0);
        check("rst_wr_ptr", 32'(wr_ptr), 32'd0);
        check("rst_wrapped", 32'(wrapped), 32'd0);
        step();
        exp_q.push_back({1'b0, 32'd0});
        rst = 1'b0;
        lat_check(4, "t1_lat");

        // 2: three writes, then read address 1.
        log_enable = 1'b1;
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 32'(i + 1) * 32'h11;
            step();
        end
        wr_valid = 1'b0;
        check("t2_wr_ptr", 32'(wr_ptr), 32'd3);
        exp_q.push_back({1'b1, 32'h22});
        r_addr = 15'd1;
        lat_check(5, "t2_lat");

        // 3: clear, then fill past the top; the re-read of address 1 collides
        // with the fill's write of address 1 and must return the old 0x22.
        exp_q.push_back({1'b1, 32'h22});
        log_clear = 1'b1;
        step();
        log_clear = 1'b0;
        check("t3_clr_wr_ptr", 32'(wr_ptr), 32'd0);
        check("t3_clr_wrapped", 32'(wrapped), 32'd0);
        check("t3_clr_r_valid", 32'(r_valid), 32'd0);
        wr_valid = 1'b1;
        for (int i = 0; i < 32770; i++) begin
            wr_data = 32'(i);
            step();
            if (i == 32766) begin
                check("t3_top_wr_ptr", 32'(wr_ptr), 32'd32767);
                check("t3_top_wrapped", 32'(wrapped), 32'd0);
            end
            if (i == 32767) begin
                check("t3_wrap_wr_ptr", 32'(wr_ptr), 32'd0);
                check("t3_wrap_wrapped", 32'(wrapped), 32'd1);
            end
        end
        wr_valid = 1'b0;
        check("t3_wr_ptr", 32'(wr_ptr), 32'd2);
        check("t3_wrapped", 32'(wrapped), 32'd1);
        exp_q.push_back({1'b1, 32'h8000});
        r_addr = 15'd0;
        lat_check(5, "t3_rd0");
        exp_q.push_back({1'b1, 32'd2});
        r_addr = 15'd2;
        lat_check(5, "t3_rd2");

        // 4: abort 5 -> 9 right after 5 was issued; only RAM[9] may appear.
        exp_q.push_back({1'b1, 32'd9});
        r_addr = 15'd5;
        step();
        check("t4_drop", 32'(r_valid), 32'd0);
        step();
        r_addr = 15'd9;
        lat_check(4, "t4_lat");

        // 5: clear wins over a simultaneous write of 0xDEAD at wr_ptr=2.
        exp_q.push_back({1'b1, 32'd9});
        log_clear = 1'b1;
        wr_valid = 1'b1;
        wr_data = 32'hDEAD;
        step();
        log_clear = 1'b0;
        wr_valid = 1'b0;
        check("t5_wr_ptr", 32'(wr_ptr), 32'd0);
        check("t5_wrapped", 32'(wrapped), 32'd0);
        check("t5_r_valid", 32'(r_valid), 32'd0);
        lat_check(4, "t5_reread");
        exp_q.push_back({1'b1, 32'd2});
        r_addr = 15'd2;
        lat_check(5, "t5_ram2");

        // 6: writes ignored while disabled; async reset in the middle of WAIT.
        wr_valid = 1'b1;
        wr_data = 32'h77;
        step();
        log_enable = 1'b0;
        wr_data = 32'h55;
        step();
        step();
        wr_valid = 1'b0;
        check("t6_disabled_wr_ptr", 32'(wr_ptr), 32'd1);
        r_addr = 15'd1;
        step();
        step();
        step();
        check("t6_midwait_r_valid", 32'(r_valid), 32'd0);
        rst = 1'b1;
        #1;
        check("t6_rst_r_valid", 32'(r_valid), 32'd0);
        check("t6_rst_r_data", r_data, 32'd0);
        check("t6_rst_wr_ptr", 32'(wr_ptr), 32'd0);
        step();
        exp_q.push_back({1'b1, 32'h8001});
        rst = 1'b0;
        lat_check(4, "t6_post_rst");

        step();
        step();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
